// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and op classification for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_DIVU = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider sharing one accumulator and shift register.
// Outputs show the value produced by the step in progress, so the owner samples them on last_step.
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last_step,
    output logic [WIDTH-1:0] o_prod_lo,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_acc;  // product low bits or partial remainder
    logic [WIDTH-1:0] r_sh;   // multiplier, or dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] r_opb;  // multiplicand (shifts left) or divisor (static)

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_opb_nxt;

    always_comb begin
        w_trial   = {r_acc, r_sh[WIDTH-1]};
        w_diff    = w_trial - {1'b0, r_opb};
        w_fits    = (w_trial >= {1'b0, r_opb});
        w_acc_nxt = r_acc;
        w_sh_nxt  = r_sh;
        w_opb_nxt = r_opb;
        if (r_is_div) begin
            w_acc_nxt = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
            w_sh_nxt  = {r_sh[WIDTH-2:0], w_fits};
        end else begin
            w_acc_nxt = r_sh[0] ? (r_acc + r_opb) : r_acc;
            w_sh_nxt  = r_sh >> 1;
            w_opb_nxt = r_opb << 1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_sh     <= '0;
            r_opb    <= '0;
        end else if (i_load) begin
            r_cnt    <= CW'(WIDTH);
            r_is_div <= i_is_div;
            r_acc    <= '0;
            r_sh     <= i_a;
            r_opb    <= i_b;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_acc <= w_acc_nxt;
            r_sh  <= w_sh_nxt;
            r_opb <= w_opb_nxt;
        end
    end

    assign o_last_step = (r_cnt == CW'(1));
    assign o_prod_lo   = w_acc_nxt;
    assign o_quot      = w_sh_nxt;
    assign o_rem       = w_acc_nxt;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake: single-cycle logic/arithmetic ops plus
// iterative unsigned MUL, DIVU and REMU.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_done,
    output logic             o_busy
);

    state_e           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_done;
    logic             r_busy;

    logic             w_accept;
    logic             w_load;
    logic             w_last_step;
    logic [WIDTH-1:0] w_basic;
    logic [WIDTH-1:0] w_iter_res;
    logic [WIDTH-1:0] w_prod_lo;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_rem;

    assign w_accept = i_start && (r_state == StIdle);
    // Zero divisor (and zero multiplier) resolve immediately without entering RUN.
    assign w_load   = w_accept && is_iter_op(i_op) && (i_b != '0);

    always_comb begin
        w_basic = '0;
        case (i_op)
            OP_ADD:  w_basic = i_a + i_b;
            OP_SUB:  w_basic = i_a - i_b;
            OP_AND:  w_basic = i_a & i_b;
            OP_OR:   w_basic = i_a | i_b;
            OP_SLT:  w_basic = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_DIVU: w_basic = '1;
            OP_REMU: w_basic = i_a;
            default: w_basic = '0;
        endcase
    end

    always_comb begin
        w_iter_res = w_rem;
        if (r_op == OP_MUL) begin
            w_iter_res = w_prod_lo;
        end else if (r_op == OP_DIVU) begin
            w_iter_res = w_quot;
        end
    end

    seq_muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_is_div   (i_op != OP_MUL),
        .i_a        (i_a),
        .i_b        (i_b),
        .o_last_step(w_last_step),
        .o_prod_lo  (w_prod_lo),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_op     <= OP_ADD;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op   <= i_op;
                        r_busy <= 1'b1;
                        if (w_load) begin
                            r_state <= StRun;
                        end else begin
                            r_state  <= StDone;
                            r_result <= w_basic;
                            r_zero   <= (w_basic == '0);
                            r_done   <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (w_last_step) begin
                        r_state  <= StDone;
                        r_result <= w_iter_res;
                        r_zero   <= (w_iter_res == '0);
                        r_done   <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_zero   = r_zero;
    assign o_done   = r_done;
    assign o_busy   = r_busy;

endmodule
